pdm_capture_ctrl: RTL and testbench

Sequencer for a PDM microphone front-end. It generates the PDM bit clock from clk_i with a programmable divider and samples the 1-bit PDM stream on a selectable edge. Bits are packed MSB-first into words and handed downstream (to the PDM-to-PCM filter or a FIFO) over a valid/ready interface. Capture runs start/stop: either continuous, or for a programmed number of words, with overflow detection.

---
 rtl/pdm_capture_pkg.sv | 13 +
 rtl/pdm_clk_div.sv | 52 +++++
 rtl/pdm_capture_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pdm_capture_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_capture_pkg.sv
// rtl/pdm_capture_pkg.sv - shared types and constants for the PDM capture sequencer
package pdm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/pdm_clk_div.sv
// rtl/pdm_clk_div.sv - programmable PDM bit-clock divider with edge strobes
//
// Ports:
//   clk_i, rst_ni  system clock, async active-low reset
//   en_i           run the divider; low clears counter and forces pdm_clk_o low
//   clkdiv_i       half-period of pdm_clk_o in clk_i cycles, minus 1
//   pdm_clk_o      divided clock (registered)
//   rise_stb_o     high in the cycle whose edge takes pdm_clk_o 0->1
//   fall_stb_o     high in the cycle whose edge takes pdm_clk_o 1->0
module pdm_clk_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [DIV_W-1:0] clkdiv_i,
    output logic             pdm_clk_o,
    output logic             rise_stb_o,
    output logic             fall_stb_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pdm_clk_q, pdm_clk_d;
    logic             toggle;

    // Strobes are derived from the registered count only, so they do not
    // depend on en_i; the caller qualifies them with its own run state.
    always_comb begin
        toggle     = (cnt_q == clkdiv_i);
        rise_stb_o = toggle & ~pdm_clk_q;
        fall_stb_o = toggle & pdm_clk_q;
        cnt_d      = toggle ? '0 : cnt_q + DIV_W'(1);
        pdm_clk_d  = pdm_clk_q ^ toggle;
        if (!en_i) begin
            cnt_d     = '0;
            pdm_clk_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pdm_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pdm_clk_q <= pdm_clk_d;
        end
    end

    assign pdm_clk_o = pdm_clk_q;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// rtl/pdm_capture_ctrl.sv - PDM microphone capture sequencer with word packing
//
// Ports:
//   clk_i, rst_ni        system clock, async active-low reset
//   start_i, stop_i      single-cycle capture start / abort requests
//   clkdiv_i             pdm_clk_o half-period minus 1 (latched on start)
//   sample_edge_i        0 = sample on rising, 1 = on falling pdm_clk_o (latched)
//   num_words_i          words to capture, 0 = continuous (latched)
//   pdm_clk_o            PDM bit clock to the microphone
//   pdm_data_i           PDM bit stream, synchronous to clk_i
//   word_o/word_valid_o/word_ready_i  packed word output, valid/ready
//   busy_o               capture in progress
//   done_o               one-cycle pulse on return to idle
//   overflow_o           sticky: a completed word was dropped
module pdm_capture_ctrl
    import pdm_capture_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [DIV_W-1:0]  clkdiv_i,
    input  logic              sample_edge_i,
    input  logic [CNT_W-1:0]  num_words_i,
    output logic              pdm_clk_o,
    input  logic              pdm_data_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);

    localparam int BIT_W = $clog2(WORD_W);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  clkdiv_q, clkdiv_d;
    logic              edge_q, edge_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [BIT_W-1:0]  bcnt_q, bcnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic              div_en, rise_stb, fall_stb;
    logic              samp, word_done, last_word, out_free;
    logic [WORD_W-1:0] next_shreg;

    pdm_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (div_en),
        .clkdiv_i   (clkdiv_q),
        .pdm_clk_o  (pdm_clk_o),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    always_comb begin
        state_d  = state_q;
        clkdiv_d = clkdiv_q;
        edge_d   = edge_q;
        num_d    = num_q;
        wcnt_d   = wcnt_q;
        bcnt_d   = bcnt_q;
        shreg_d  = shreg_q;
        word_d   = word_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        samp       = (state_q == RUN) && ((edge_q == EDGE_FALL) ? fall_stb : rise_stb);
        next_shreg = {shreg_q[WORD_W-2:0], pdm_data_i};
        word_done  = samp && (bcnt_q == BIT_W'(WORD_W - 1));
        last_word  = word_done && (num_q != '0) && (wcnt_q == num_q - CNT_W'(1));
        out_free   = !valid_q || word_ready_i;
        // Dropping enable in the cycle RUN is left makes pdm_clk_o low
        // exactly on entry to DRAIN rather than one cycle later.
        div_en     = (state_q == RUN) && !(stop_i || last_word);

        if (valid_q && word_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    clkdiv_d = clkdiv_i;
                    edge_d   = sample_edge_i;
                    num_d    = num_words_i;
                    wcnt_d   = '0;
                    bcnt_d   = '0;
                    shreg_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            RUN: begin
                if (samp) begin
                    shreg_d = next_shreg;
                    bcnt_d  = word_done ? '0 : bcnt_q + BIT_W'(1);
                end
                if (word_done) begin
                    if (wcnt_q != '1) begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                    if (out_free) begin
                        word_d  = next_shreg;
                        valid_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (stop_i || last_word) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_free) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            clkdiv_q <= '0;
            edge_q   <= 1'b0;
            num_q    <= '0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            shreg_q  <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            clkdiv_q <= clkdiv_d;
            edge_q   <= edge_d;
            num_q    <= num_d;
            wcnt_q   <= wcnt_d;
            bcnt_q   <= bcnt_d;
            shreg_q  <= shreg_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb/tb_pdm_capture_ctrl.sv - self-checking bench for pdm_capture_ctrl
module tb_pdm_capture_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [15:0] clkdiv_i = '0;
    logic        sample_edge_i = 1'b0;
    logic [15:0] num_words_i = '0;
    logic        pdm_clk_o;
    logic        pdm_data_i = 1'b0;
    logic [7:0]  word_o;
    logic        word_valid_o;
    logic        word_ready_i = 1'b1;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model of one capture run: k counts cycles since busy_o rose.
    bit   m_act = 1'b0;
    bit   drv_act = 1'b0;
    bit   m_fall = 1'b0;
    int   m_d = 0;
    int   m_k0 = 0;
    int   m_klast = 0;
    bit   bits[64];
    int   first_rise = -1;
    int   n_done = 0;
    int   n_obs = 0;
    logic [7:0] obs[8];

    pdm_capture_ctrl #(.DIV_W(16), .WORD_W(8), .CNT_W(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .clkdiv_i      (clkdiv_i),
        .sample_edge_i (sample_edge_i),
        .num_words_i   (num_words_i),
        .pdm_clk_o     (pdm_clk_o),
        .pdm_data_i    (pdm_data_i),
        .word_o        (word_o),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle (k) in which sample j is taken: the toggle number n that reaches the
    // chosen level is 2j+1 for rising, 2j+2 for falling; toggles occur every d+1 cycles.
    function automatic int ks(input int j);
        return ((m_fall ? 2 * j + 2 : 2 * j + 1) * (m_d + 1)) - 1;
    endfunction

    // Bit to present in cycle k: the one the next upcoming sample will take.
    function automatic bit data_at(input int k);
        int n, j;
        if (k < 0) return 1'b0;
        n = (k + 1 + m_d) / (m_d + 1);
        j = m_fall ? (n - 1) / 2 : n / 2;
        return (j < 64) ? bits[j] : 1'b0;
    endfunction

    function automatic logic [7:0] word_of(input int w);
        logic [7:0] v;
        v = '0;
        for (int b = 0; b < 8; b++) v = {v[6:0], bits[8 * w + b]};
        return v;
    endfunction

    task automatic set_bits(input logic [63:0] v);
        for (int i = 0; i < 64; i++) bits[i] = v[63 - i];
    endtask

    task automatic to_k(input int kk);
        while (cyc - m_k0 < kk) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic start_cap(input int d, input bit fall, input int nw, input bit stp, input bit chkm);
        @(posedge clk_i);
        #1;
        clkdiv_i      = 16'(d);
        sample_edge_i = fall;
        num_words_i   = 16'(nw);
        start_i       = 1'b1;
        stop_i        = stp;
        m_d           = d;
        m_fall        = fall;
        m_k0          = cyc + 1;
        m_klast       = (nw > 0) ? ks(8 * nw - 1) + 1 : 1000000;
        first_rise    = -1;
        n_done        = 0;
        n_obs         = 0;
        drv_act       = 1'b1;
        m_act         = chkm;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    initial forever begin
        @(posedge clk_i);
        #1;
        pdm_data_i = drv_act ? data_at(cyc - m_k0) : 1'b0;
    end

    // Per-cycle comparison against the model while a checked run is active.
    always @(negedge clk_i) begin : cmp
        int k;
        logic eb, ed, ec, ev;
        logic [7:0] ew;
        k = cyc - m_k0;
        if (m_act && k >= 0 && k <= m_klast + 2) begin
            eb = (k <= m_klast);
            ed = (k == m_klast + 1);
            ec = (k < m_klast) ? (((k / (m_d + 1)) % 2) == 1) : 1'b0;
            ev = 1'b0;
            ew = '0;
            for (int w = 0; w < 8; w++) begin
                if (ks(8 * w + 7) < m_klast && k == ks(8 * w + 7) + 1) begin
                    ev = 1'b1;
                    ew = word_of(w);
                end
            end
            chk("busy", busy_o, eb);
            chk("done", done_o, ed);
            chk("pdm_clk", pdm_clk_o, ec);
            chk("valid", word_valid_o, ev);
            if (ev) chk("word", word_o, ew);
            chk("overflow", overflow_o, 1'b0);
            if (pdm_clk_o && first_rise < 0) first_rise = k;
            if (word_valid_o && n_obs < 8) begin
                obs[n_obs] = word_o;
                n_obs++;
            end
            if (done_o) n_done++;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_valid", word_valid_o, 1'b0);
        chk("rst_word", word_o, 8'h00);
        chk("rst_pdm_clk", pdm_clk_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_ovf", overflow_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // clkdiv=1, rising, one word 0xA5
        set_bits(64'hA500_0000_0000_0000);
        start_cap(1, 1'b0, 1, 1'b0, 1'b1);
        to_k(m_klast + 3);
        m_act = 1'b0; drv_act = 1'b0;
        chk("s1_first_rise", first_rise, 2);
        chk("s1_nwords", n_obs, 1);
        chk("s1_word", obs[0], 8'hA5);
        chk("s1_done_cnt", n_done, 1);

        // clkdiv=0, falling, three words of ones
        set_bits(64'hFFFF_FFFF_FFFF_FFFF);
        start_cap(0, 1'b1, 3, 1'b0, 1'b1);
        to_k(m_klast + 3);
        m_act = 1'b0; drv_act = 1'b0;
        chk("s2_first_rise", first_rise, 1);
        chk("s2_nwords", n_obs, 3);
        for (int i = 0; i < 3; i++) chk("s2_word", obs[i], 8'hFF);
        chk("s2_done_cnt", n_done, 1);

        // Backpressure: ready low, words 2 and 3 dropped
        word_ready_i = 1'b0;
        set_bits(64'h5A11_2200_0000_0000);
        start_cap(0, 1'b0, 3, 1'b0, 1'b0);
        to_k(20);
        @(negedge clk_i);
        chk("bp_valid20", word_valid_o, 1'b1);
        chk("bp_word20", word_o, 8'h5A);
        to_k(40);
        @(negedge clk_i);
        chk("bp_word40", word_o, 8'h5A);
        chk("bp_ovf40", overflow_o, 1'b1);
        to_k(60);
        @(negedge clk_i);
        chk("bp_busy60", busy_o, 1'b1);
        chk("bp_word60", word_o, 8'h5A);
        chk("bp_pdmclk60", pdm_clk_o, 1'b0);
        chk("bp_done60", done_o, 1'b0);
        @(posedge clk_i);
        #1;
        word_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_busy61", busy_o, 1'b1);
        chk("bp_done61", done_o, 1'b0);
        @(negedge clk_i);
        chk("bp_busy62", busy_o, 1'b0);
        chk("bp_done62", done_o, 1'b1);
        chk("bp_valid62", word_valid_o, 1'b0);
        @(negedge clk_i);
        chk("bp_done63", done_o, 1'b0);
        chk("bp_ovf63", overflow_o, 1'b1);
        drv_act = 1'b0;

        // Continuous mode, stop after 12 bits
        set_bits(64'h3CB0_0000_0000_0000);
        start_cap(0, 1'b0, 0, 1'b0, 1'b1);
        m_klast = 24;
        to_k(23);
        stop_i = 1'b1;
        @(posedge clk_i);
        #1;
        stop_i = 1'b0;
        to_k(m_klast + 3);
        m_act = 1'b0; drv_act = 1'b0;
        chk("s4_nwords", n_obs, 1);
        chk("s4_word", obs[0], 8'h3C);
        chk("s4_done_cnt", n_done, 1);

        // start+stop together; restart and config changes mid-run ignored
        set_bits(64'h9600_0000_0000_0000);
        start_cap(2, 1'b0, 1, 1'b1, 1'b1);
        to_k(10);
        start_i = 1'b1; clkdiv_i = 16'd0; sample_edge_i = 1'b1; num_words_i = 16'd5;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        to_k(m_klast + 3);
        m_act = 1'b0; drv_act = 1'b0;
        chk("s5_first_rise", first_rise, 3);
        chk("s5_nwords", n_obs, 1);
        chk("s5_word", obs[0], 8'h96);
        chk("s5_done_cnt", n_done, 1);

        // Asynchronous reset mid-run with a word pending
        word_ready_i = 1'b0;
        set_bits(64'hC3C3_0000_0000_0000);
        start_cap(0, 1'b0, 0, 1'b0, 1'b0);
        to_k(35);
        @(negedge clk_i);
        chk("ar_valid_pre", word_valid_o, 1'b1);
        chk("ar_ovf_pre", overflow_o, 1'b1);
        chk("ar_pdmclk_pre", pdm_clk_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("ar_busy", busy_o, 1'b0);
        chk("ar_valid", word_valid_o, 1'b0);
        chk("ar_word", word_o, 8'h00);
        chk("ar_pdm_clk", pdm_clk_o, 1'b0);
        chk("ar_ovf", overflow_o, 1'b0);
        chk("ar_done", done_o, 1'b0);
        drv_act = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        word_ready_i = 1'b1;

        // Normal capture after reset
        set_bits(64'hA500_0000_0000_0000);
        start_cap(1, 1'b0, 1, 1'b0, 1'b1);
        to_k(m_klast + 3);
        m_act = 1'b0; drv_act = 1'b0;
        chk("s7_word", obs[0], 8'hA5);
        chk("s7_done_cnt", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL timeout: simulation did not finish within bound");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
